pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Instruction-fetch stage ahead of the ALU. Holds the PC, fetches via a req/ack
//  memory handshake and presents INSTR to decode/ALU under a valid/ready handshake.
//  Consumes ALU branch outcome (SIG_B) plus the 16-bit immediate (RAW_VAL) or a
//  jump target to form the next PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  MAX_WAIT   15             cycles without IMEM_ACK before FETCH_ERR (1..255)
// PORTS
//  CLK          in   1   clock, all regs on rising edge
//  RST          in   1   synchronous, active-high reset
//  IMEM_REQ     out  1   fetch request, high while in FETCH
//  IMEM_ADDR    out  32  fetch address (= PC)
//  IMEM_ACK     in   1   memory returns IMEM_DATA this cycle
//  IMEM_DATA    in   32  instruction word
//  INSTR        out  32  instruction to decode/ALU
//  INSTR_VALID  out  1   INSTR valid
//  INSTR_READY  in   1   downstream accepts INSTR (execute done, branch resolved)
//  PC           out  32  address of INSTR
//  BR_VALID     in   1   SIG_B/RAW_VAL describe the instruction being accepted
//  SIG_B        in   1   ALU branch-taken flag
//  RAW_VAL      in   16  branch immediate (word offset)
//  JUMP         in   1   accepted instruction is a jump
//  JUMP_TARGET  in   26  jump target field
//  FETCH_ERR    out  1   sticky: an ack timeout occurred
// BEHAVIOUR
//  - One clock (CLK), RST synchronous active-high; RST has priority over everything.
//  - Reset values: PC=IMEM_ADDR=RESET_PC, IMEM_REQ=0, INSTR=0, INSTR_VALID=0,
//    FETCH_ERR=0, state=IDLE, wait counter=0, pending redirect cleared.
//  - States: IDLE -> FETCH (unconditional, first cycle after RST low).
//    FETCH: IMEM_REQ=1, IMEM_ADDR=PC. IMEM_ACK=1 -> INSTR<=IMEM_DATA, INSTR_VALID<=1,
//    go HOLD, counter cleared. No ack -> counter++; counter reaching MAX_WAIT sets
//    FETCH_ERR, clears counter, REQ stays high (retry, same address).
//    HOLD: IMEM_REQ=0, INSTR/PC stable while INSTR_VALID & !INSTR_READY.
//    INSTR_VALID & INSTR_READY -> PC<=next PC, INSTR_VALID<=0, go FETCH.
//  - IMEM_ACK outside FETCH is ignored. Min 2 cycles/instruction (ack and ready same cycle).
//  - Next PC (sampled in handshake cycle), all mod 2^32:
//    BR_VALID&SIG_B : PC+4 + ({{14{RAW_VAL[15]}},RAW_VAL,2'b00})
//    else JUMP      : {PC4[31:28], JUMP_TARGET, 2'b00}, PC4=PC+4
//    else           : PC+4   (branch taken beats JUMP if both asserted)
//  - BR_VALID/SIG_B/JUMP ignored outside the handshake cycle.
//  - PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
//  - Reset mid-fetch/mid-hold: outstanding request abandoned, late ack ignored
//    (IDLE state), held INSTR discarded.
// CONFIGURATION
//  DELAY_SLOT_EN defined: a taken branch/jump stores its target as pending; next
//    fetch is PC+4 (delay slot); after the delay-slot handshake PC<=pending target.
//    Branch/jump resolving during the delay-slot handshake is ignored.
//  Not defined: redirect applies at the branch handshake; no pending register.
// TESTING
//  1 Reset, RESET_PC=0, ack same cycle as REQ, READY=1 -> PC 0,4,8,C; INSTR_VALID
//    every 2nd cycle; first IMEM_REQ one cycle after RST low.
//  2 PC=0x10, BNE: BR_VALID=1,SIG_B=1 (RS=15,RT=12),RAW_VAL=3 -> next PC 0x20;
//    same with SIG_B=0 (RS=RT=15) -> 0x14; RAW_VAL=16'hFFFE at PC 0x20 -> 0x1C.
//  3 JUMP=1,JUMP_TARGET=26'h40 at PC 0x8 -> 0x100; JUMP and taken branch together -> branch.
//  4 MAX_WAIT=15, ack withheld 20 cycles -> FETCH_ERR=1 after 15 cycles and stays 1,
//    IMEM_REQ high throughout, ack at cycle 20 delivers INSTR at same address.
//  5 READY low 5 cycles in HOLD -> INSTR/PC stable, no REQ; RST asserted in FETCH with
//    ack next cycle -> ack ignored, PC=RESET_PC; RESET_PC=32'hFFFF_FFFC -> next 0x0.
//  6 DELAY_SLOT_EN: taken branch at 0x10 to 0x40 -> fetch 0x14 then 0x40; without -> 0x40.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack fetch from instruction memory, valid/ready hand-off.
// Optional branch delay slot selected by defining DELAY_SLOT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic        br_valid,
  input  logic        sig_b,
  input  logic [15:0] raw_val,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic        fetch_err
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_cnt;
  logic [31:0] pc_plus4;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] redirect_pc;
  logic [31:0] next_pc;
  logic        branch_taken;
  logic        redirect;
  logic        handshake;
  logic        wait_expired;

  assign pc_plus4     = pc + 32'd4;
  assign branch_pc    = pc_plus4 + {{14{raw_val[15]}}, raw_val, 2'b00};
  assign jump_pc      = {pc_plus4[31:28], jump_target, 2'b00};
  assign branch_taken = br_valid & sig_b;
  assign redirect     = branch_taken | jump;
  // A taken branch wins over a jump flagged in the same handshake.
  assign redirect_pc  = branch_taken ? branch_pc : jump_pc;
  assign handshake    = (state == HOLD) & instr_valid & instr_ready;
  assign wait_expired = (wait_cnt == WAIT_LAST);

`ifdef DELAY_SLOT_EN
  logic        pending_valid;
  logic [31:0] pending_pc;

  // The redirect is parked for one instruction; the delay-slot handshake consumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_valid <= 1'b0;
      pending_pc    <= 32'h0;
    end else if (handshake) begin
      if (pending_valid) begin
        pending_valid <= 1'b0;
      end else if (redirect) begin
        pending_valid <= 1'b1;
        pending_pc    <= redirect_pc;
      end
    end
  end

  always_comb begin
    next_pc = pending_valid ? pending_pc : pc_plus4;
  end
`else
  always_comb begin
    next_pc = redirect ? redirect_pc : pc_plus4;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = FETCH;
      FETCH:   next_state = imem_ack ? HOLD : FETCH;
      HOLD:    next_state = handshake ? FETCH : HOLD;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == FETCH);
    imem_addr = pc;
  end

  // Timeout retries the same address; the error flag stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= 8'h0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_data;
            instr_valid <= 1'b1;
            wait_cnt    <= 8'h0;
          end else if (wait_expired) begin
            fetch_err <= 1'b1;
            wait_cnt  <= 8'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (handshake) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized fetch/branch traffic
// checked against an arithmetic next-PC model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_ready;
  logic        br_valid;
  logic        sig_b;
  logic [15:0] raw_val;
  logic        jump;
  logic [25:0] jump_target;

  logic        imem_req, instr_valid, fetch_err;
  logic [31:0] imem_addr, instr, pc;
  logic        w_imem_req, w_instr_valid, w_fetch_err;
  logic [31:0] w_imem_addr, w_instr, w_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .br_valid(br_valid), .sig_b(sig_b), .raw_val(raw_val), .jump(jump),
    .jump_target(jump_target), .fetch_err(fetch_err)
  );

  // Second instance exists only to observe the wrap from the top of the address space.
  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(15)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr(w_instr),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready), .pc(w_pc),
    .br_valid(br_valid), .sig_b(sig_b), .raw_val(raw_val), .jump(jump),
    .jump_target(jump_target), .fetch_err(w_fetch_err)
  );

  function automatic logic [31:0] model_next(input logic [31:0] cur, input bit bv, input bit sb,
                                             input logic [15:0] raw, input bit j, input logic [25:0] jt);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (bv && sb) return seq + 32'($signed(raw)) * 32'd4;
    if (j) return (seq & 32'hF000_0000) | (32'(jt) << 2);
    return seq;
  endfunction

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    br_valid = 1'b0; sig_b = 1'b0; jump = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits for a request, withholds ack for ack_delay cycles, then returns what HOLD shows.
  task automatic fetch_one(input int ack_delay, input logic [31:0] data,
                           output bit got_req, output logic [31:0] addr_seen, output bit req_held,
                           output logic [31:0] instr_seen, output logic [31:0] pc_seen,
                           output logic valid_seen);
    got_req = 1'b0;
    req_held = 1'b1;
    for (int n = 0; n < 40 && !got_req; n++) begin
      if (imem_req === 1'b1) got_req = 1'b1;
      else @(negedge clk);
    end
    addr_seen = imem_addr;
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== addr_seen) req_held = 1'b0;
    end
    imem_ack = 1'b1;
    imem_data = data;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_data = $urandom;
    instr_seen = instr;
    pc_seen = pc;
    valid_seen = instr_valid;
  endtask

  // Holds ready low (with noise on every ignored input), then completes one handshake.
  task automatic accept_one(input int rdy_delay, input bit bv, input bit sb, input logic [15:0] raw,
                            input bit j, input logic [25:0] jt, output bit stable);
    logic [31:0] i0, p0;
    i0 = instr;
    p0 = pc;
    stable = 1'b1;
    for (int i = 0; i < rdy_delay; i++) begin
      instr_ready = 1'b0;
      imem_ack = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      br_valid = 1'($urandom_range(0, 1)); sig_b = 1'($urandom_range(0, 1));
      jump = 1'($urandom_range(0, 1)); raw_val = 16'($urandom); jump_target = 26'($urandom);
      @(negedge clk);
      if (instr !== i0 || pc !== p0 || instr_valid !== 1'b1 || imem_req !== 1'b0) stable = 1'b0;
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1;
    br_valid = bv; sig_b = sb; raw_val = raw; jump = j; jump_target = jt;
    @(negedge clk);
    instr_ready = 1'b0;
    br_valid = 1'($urandom_range(0, 1)); sig_b = 1'($urandom_range(0, 1));
    jump = 1'($urandom_range(0, 1)); raw_val = 16'($urandom); jump_target = 26'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_data = 32'h0; instr_ready = 1'b0;
    br_valid = 1'b0; sig_b = 1'b0; raw_val = 16'h0; jump = 1'b0; jump_target = 26'h0;
    repeat (3) @(negedge clk);
    total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h want %h", pc, 32'h0); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr: got %h want %h", imem_addr, 32'h0); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
    total++; if (instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr: got %h want 0", instr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", instr_valid); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", fetch_err); end
    total++; if (w_pc !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL reset_pc_top: got %h want fffffffc", w_pc); end
    rst = 1'b0;
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL req_at_release: got %b want 0", imem_req); end
    @(negedge clk);
    total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL first_req: got %b want 1", imem_req); end
  endtask

  task automatic test_sequential();
    bit got, held, stable;
    logic [31:0] a, iv, pv, d;
    logic v;
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      fetch_one(0, d, got, a, held, iv, pv, v);
      total++; if (!got || a !== 32'(4 * k)) begin bad++; $display("[TB] FAIL seq_addr: got %h want %h", a, 32'(4 * k)); end
      total++; if (v !== 1'b1 || iv !== d) begin bad++; $display("[TB] FAIL seq_instr: got %h/%b want %h/1", iv, v, d); end
      total++; if (pv !== 32'(4 * k)) begin bad++; $display("[TB] FAIL seq_pc: got %h want %h", pv, 32'(4 * k)); end
      accept_one(0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, stable);
      total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL seq_valid_drop: got %b want 0", instr_valid); end
      if (k == 0) begin
        total++; if (w_pc !== 32'h0) begin bad++; $display("[TB] FAIL pc_wrap: got %h want 00000000", w_pc); end
      end
    end
  endtask

  task automatic test_branch();
    bit got, held, stable, bv, sb, j;
    logic [31:0] a, iv, pv, d, cur, nxt;
    logic [15:0] raw;
    logic [25:0] jt;
    logic v;
    do_reset();
    cur = 32'h0;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin bv = 0; sb = 0; raw = 16'h0;    j = 1; jt = 26'h4;  nxt = 32'h10;  end
        1: begin bv = 1; sb = 0; raw = 16'h3;    j = 0; jt = 26'h0;  nxt = 32'h14;  end
        2: begin bv = 0; sb = 0; raw = 16'h0;    j = 1; jt = 26'h4;  nxt = 32'h10;  end
        3: begin bv = 1; sb = 1; raw = 16'h3;    j = 0; jt = 26'h0;  nxt = 32'h20;  end
        4: begin bv = 1; sb = 1; raw = 16'hFFFE; j = 0; jt = 26'h0;  nxt = 32'h1C;  end
        5: begin bv = 0; sb = 0; raw = 16'h0;    j = 1; jt = 26'h2;  nxt = 32'h08;  end
        6: begin bv = 0; sb = 0; raw = 16'h0;    j = 1; jt = 26'h40; nxt = 32'h100; end
        7: begin bv = 1; sb = 1; raw = 16'h1;    j = 1; jt = 26'h40; nxt = 32'h108; end
        default: begin bv = 0; sb = 1; raw = 16'h5; j = 0; jt = 26'h0; nxt = 32'h10C; end
      endcase
      d = $urandom;
      fetch_one(i % 3, d, got, a, held, iv, pv, v);
      total++; if (!got || a !== cur) begin bad++; $display("[TB] FAIL br_fetch_addr step %0d: got %h want %h", i, a, cur); end
      total++; if (v !== 1'b1 || iv !== d || pv !== cur) begin bad++; $display("[TB] FAIL br_hold step %0d: got %h@%h want %h@%h", i, iv, pv, d, cur); end
      accept_one(i % 2, bv, sb, raw, j, jt, stable);
      cur = nxt;
    end
    total++; if (imem_req !== 1'b1 || imem_addr !== cur) begin bad++; $display("[TB] FAIL br_final_addr: got %h want %h", imem_addr, cur); end
  endtask

  task automatic test_delay_slot();
    bit got, held, stable;
    logic [31:0] a, iv, pv;
    logic v;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      fetch_one(0, $urandom, got, a, held, iv, pv, v);
      accept_one(0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, stable);
    end
    fetch_one(0, $urandom, got, a, held, iv, pv, v);
    total++; if (a !== 32'h10) begin bad++; $display("[TB] FAIL ds_branch_addr: got %h want 00000010", a); end
    accept_one(0, 1'b1, 1'b1, 16'd11, 1'b0, 26'h0, stable);
`ifdef DELAY_SLOT_EN
    fetch_one(0, $urandom, got, a, held, iv, pv, v);
    total++; if (a !== 32'h14) begin bad++; $display("[TB] FAIL ds_slot_addr: got %h want 00000014", a); end
    accept_one(0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h123, stable);
`endif
    fetch_one(0, $urandom, got, a, held, iv, pv, v);
    total++; if (a !== 32'h40) begin bad++; $display("[TB] FAIL ds_target_addr: got %h want 00000040", a); end
    accept_one(0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, stable);
    total++; if (imem_addr !== 32'h44) begin bad++; $display("[TB] FAIL ds_after_addr: got %h want 00000044", imem_addr); end
  endtask

  task automatic test_timeout();
    logic [31:0] a0, d;
    bit held, stable;
    held = 1'b1;
    imem_ack = 1'b0;
    a0 = imem_addr;
    total++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("[TB] FAIL to_start: got err=%b req=%b want 0/1", fetch_err, imem_req); end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== a0) held = 1'b0;
      if (i == 14) begin
        total++; if (fetch_err !== 1'b0) begin bad++; $display("[TB] FAIL to_early_err: got %b want 0", fetch_err); end
      end
      if (i >= 15) begin
        total++; if (fetch_err !== 1'b1) begin bad++; $display("[TB] FAIL to_err cycle %0d: got %b want 1", i, fetch_err); end
      end
    end
    total++; if (!held) begin bad++; $display("[TB] FAIL to_req_held: got 0 want 1"); end
    d = $urandom;
    imem_ack = 1'b1; imem_data = d;
    @(negedge clk);
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b1 || instr !== d || pc !== a0) begin bad++; $display("[TB] FAIL to_late_ack: got %h@%h want %h@%h", instr, pc, d, a0); end
    accept_one(0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, stable);
    total++; if (fetch_err !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky: got %b want 1", fetch_err); end
  endtask

  task automatic test_hold_reset();
    bit got, held, stable;
    logic [31:0] a, iv, pv, d;
    logic v;
    do_reset();
    total++; if (fetch_err !== 1'b0) begin bad++; $display("[TB] FAIL err_cleared: got %b want 0", fetch_err); end
    d = $urandom;
    fetch_one(1, d, got, a, held, iv, pv, v);
    accept_one(5, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, stable);
    total++; if (!stable) begin bad++; $display("[TB] FAIL hold_stable: got 0 want 1"); end
    total++; if (imem_addr !== 32'h4) begin bad++; $display("[TB] FAIL hold_next: got %h want 00000004", imem_addr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b1; imem_data = $urandom;
    @(negedge clk);
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b1) begin bad++; $display("[TB] FAIL rst_fetch: got v=%b pc=%h req=%b want 0/00000000/1", instr_valid, pc, imem_req); end
    fetch_one(0, 32'hDEAD_BEEF, got, a, held, iv, pv, v);
    rst = 1'b1;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_hold: got v=%b instr=%h req=%b want 0/0/0", instr_valid, instr, imem_req); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_hold_refetch: got %b@%h want 1@00000000", imem_req, imem_addr); end
  endtask

  task automatic test_random();
    bit got, held, stable, bv, sb, j;
    logic [31:0] a, iv, pv, d, m_pc;
    logic [15:0] raw;
    logic [25:0] jt;
    logic v;
`ifdef DELAY_SLOT_EN
    bit m_pend;
    logic [31:0] m_tgt;
    m_pend = 1'b0;
    m_tgt = 32'h0;
`endif
    do_reset();
    m_pc = 32'h0;
    for (int n = 0; n < 200; n++) begin
      d = $urandom;
      fetch_one(int'($urandom_range(0, 4)), d, got, a, held, iv, pv, v);
      total++; if (!got || !held || a !== m_pc) begin bad++; $display("[TB] FAIL rnd_fetch %0d: got %h want %h", n, a, m_pc); end
      total++; if (v !== 1'b1 || iv !== d || pv !== m_pc) begin bad++; $display("[TB] FAIL rnd_hold %0d: got %h@%h want %h@%h", n, iv, pv, d, m_pc); end
      bv = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1)); j = ($urandom_range(0, 3) == 0);
      raw = 16'($urandom); jt = 26'($urandom);
      accept_one(int'($urandom_range(0, 3)), bv, sb, raw, j, jt, stable);
      total++; if (!stable) begin bad++; $display("[TB] FAIL rnd_stable %0d: got 0 want 1", n); end
`ifdef DELAY_SLOT_EN
      if (m_pend) begin m_pc = m_tgt; m_pend = 1'b0; end
      else if ((bv && sb) || j) begin m_tgt = model_next(m_pc, bv, sb, raw, j, jt); m_pend = 1'b1; m_pc = m_pc + 32'd4; end
      else m_pc = m_pc + 32'd4;
`else
      m_pc = model_next(m_pc, bv, sb, raw, j, jt);
`endif
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
`ifndef DELAY_SLOT_EN
    test_branch();
`endif
    test_delay_slot();
    test_timeout();
    test_hold_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
